ysyx_25040111_refill_axi_rd: RTL and testbench
==============================================

# ysyx_25040111_refill_axi_rd

AXI4 read-burst master that serves instruction-cache refills. It sits directly downstream of the I-cache: it accepts the cache's `rstart`/`rlen` refill request plus the miss address, issues one AR burst, and returns each R beat to the cache as a registered `rok`/`rdata` pulse. It is the only path from the cache to the memory crossbar.

## Interface
Parameters:
- `ARID_VAL`, default 0: constant driven on `arid`; also the expected `rid`.
- `MAX_LEN`, default 8'd15: largest accepted `rlen`; larger requests are clamped to it.

Ports:
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rstart` in 1: refill request pulse from cache.
- `raddr` in 32: refill base address, sampled with `rstart`.
- `rlen` in 8: AXI ARLEN encoding, beats − 1, sampled with `rstart`.
- `rok` out 1: one-cycle pulse per returned beat.
- `rdata` out 32: beat data; valid while `rok`=1.
- `rdone` out 1: one-cycle pulse, coincident with the final `rok`.
- `rerr` out 1: one-cycle pulse with `rdone` when the burst had an error.
- `busy` out 1: high from request acceptance until `rdone`.
- AR channel: `arvalid` out 1, `arready` in 1, `araddr` out 32, `arid` out 4, `arlen` out 8, `arsize` out 3, `arburst` out 2.
- R channel: `rvalid` in 1, `rready` out 1, `axi_rdata` in 32, `rresp` in 2, `rlast` in 1, `rid` in 4.

## Operation
- States: IDLE, ADDR, DATA.
- IDLE: `rstart`=1 latches `araddr` = `raddr & ~32'h3` and `arlen` = min(`rlen`, `MAX_LEN`), and clears the beat counter. The state goes to ADDR and `busy` is set.
- `rstart` while `busy`=1 is ignored. It is not queued.
- ADDR: `arvalid`=1 with `arsize`=3'b010 and `arburst`=2'b01 (INCR). `arvalid` and all AR fields stay stable until `arready`. On handshake the state goes to DATA.
- DATA: `rready`=1 continuously. On each R handshake:
  - the next cycle carries `rok`=1 with `rdata` = `axi_rdata`;
  - the 8-bit beat counter increments;
  - `rresp[1]`=1 sets a sticky error flag.
- End of burst:
  - The burst ends on the handshake where `rlast`=1.
  - The next cycle carries the final `rok` together with `rdone` (and `rerr` if the flag is set). `busy` drops in that same cycle and the state returns to IDLE.
  - A new `rstart` is accepted in that same cycle.
- Reset (asynchronous, any state): state→IDLE; counter, error flag and latched fields cleared. Outputs go to 0: `arvalid`, `rready`, `rok`, `rdone`, `rerr`, `busy`, `rdata`, `araddr`, `arlen`. `arid`=`ARID_VAL`, `arsize`=3'b010, `arburst`=2'b01.
- Reset mid-burst abandons the transaction. Beats still outstanding at the slave are not consumed after reset.

## Timing
- `rstart` at edge N → `arvalid`=1 from N+1.
- AR handshake at edge M → `rready`=1 from M+1. `rready` is deasserted in IDLE and ADDR.
- R handshake at edge K → `rok` pulse during cycle K+1.
- Minimum burst of one beat: `rstart` at N, `arready` already high, `rvalid` at N+2 → `rok`/`rdone` at N+3.
- No back-pressure toward the cache: `rok` pulses may occur on consecutive cycles, one per beat.

## Configuration
- `YSYX_25040111_AXI_CHK_EN` defined: protocol checks run. Each of the following sets the error flag:
  - `rid` ≠ `ARID_VAL`;
  - `rlast`=1 with counter ≠ `arlen`;
  - counter reaching `arlen` without `rlast`.
  In that last case the burst also terminates at the `arlen`-th beat.
- Macro undefined: only the `rresp` check is present. Termination is on `rlast` alone.

## Structure
- The shared package `ysyx_25040111_axi_pkg` holds:
  - AXI constants: BURST_INCR=2'b01, SIZE_4B=3'b010, RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - the state encoding IDLE/ADDR/DATA.
- One sub-module, `ysyx_25040111_axi_rchk`: the beat/`rid`/`rlast` checker, instantiated only under `YSYX_25040111_AXI_CHK_EN`. The FSM, counter and output registers stay flat in the top.

## Test plan
- Single beat: `rstart`, `raddr`=32'h3000_0006, `rlen`=0, `arready`=1. Required: `araddr`=32'h3000_0004, `arlen`=0; then on `axi_rdata`=32'hDEAD_BEEF, `rlast`=1, one cycle later `rok`=`rdone`=1, `rdata`=32'hDEAD_BEEF, `rerr`=0.
- 4-beat burst with `arready` delayed 3 cycles and `rvalid` gaps. Required: `arvalid` and fields stable through the stall; exactly 4 `rok` pulses in order; `rdone` with the 4th only.
- Error response: `rresp`=2'b10 on beat 2 of a 4-beat burst. Required: all 4 `rok` pulses; `rerr`=1 with `rdone`.
- `rstart` while `busy`: second request ignored, no second AR. `rstart` in the `rdone` cycle: new AR next cycle.
- Reset pulled low mid-DATA after 2 of 4 beats. Required: same cycle `busy`=`rready`=`rok`=0, state IDLE; after release, a fresh request completes normally.
- With `YSYX_25040111_AXI_CHK_EN`: `rlast` on beat 2 of an `arlen`=3 burst → `rdone` and `rerr` on that beat. Mismatched `rid` → `rerr`=1.

Source files
------------

// File: rtl/ysyx_25040111_axi_pkg.sv
// Shared AXI4 constants and refill FSM state encoding.
// Imported by the refill read master and its beat checker.
package ysyx_25040111_axi_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_4B     = 3'b010;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } rd_state_e;

endpackage

// File: rtl/ysyx_25040111_axi_rchk.sv
// R-beat protocol checker: rid match and rlast vs beat count.
// Only instantiated when YSYX_25040111_AXI_CHK_EN is defined.
module ysyx_25040111_axi_rchk
  import ysyx_25040111_axi_pkg::*;
#(
  parameter logic [3:0] ARID_VAL = 4'd0
) (
  input  logic [3:0] i_rid,
  input  logic       i_rlast,
  input  logic [7:0] i_cnt,
  input  logic [7:0] i_arlen,
  output logic       o_err,
  output logic       o_end
);

  logic w_id_bad;
  logic w_at_len;
  logic w_early;
  logic w_miss;

  assign w_id_bad = (i_rid != ARID_VAL);
  assign w_at_len = (i_cnt == i_arlen);
  assign w_early  = i_rlast & ~w_at_len;
  assign w_miss   = ~i_rlast & w_at_len;

  // The counter reaching arlen closes the burst even if rlast never comes.
  assign o_err = w_id_bad | w_early | w_miss;
  assign o_end = i_rlast | w_at_len;

endmodule

// File: rtl/ysyx_25040111_refill_axi_rd.sv
// I-cache refill AXI4 read-burst master: one AR, beats out as rok pulses.
// Define YSYX_25040111_AXI_CHK_EN to add rid/rlast/beat-count checks.
module ysyx_25040111_refill_axi_rd
  import ysyx_25040111_axi_pkg::*;
#(
  parameter logic [3:0] ARID_VAL = 4'd0,
  parameter logic [7:0] MAX_LEN  = 8'd15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rstart,
  input  logic [31:0] raddr,
  input  logic [7:0]  rlen,
  output logic        rok,
  output logic [31:0] rdata,
  output logic        rdone,
  output logic        rerr,
  output logic        busy,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic [3:0]  rid
);

  rd_state_e   r_state;
  logic [7:0]  r_cnt;
  logic        r_err;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_rok;
  logic        r_rdone;
  logic        r_rerr;
  logic        r_busy;
  logic [31:0] r_rdata;
  logic [31:0] r_araddr;
  logic [7:0]  r_arlen;

  logic        w_rhs;
  logic        w_beat_err;
  logic        w_beat_end;
  logic        w_unused;

  assign w_rhs    = rvalid & r_rready;
  assign w_unused = ^{rresp[0], rid};

`ifdef YSYX_25040111_AXI_CHK_EN
  logic w_chk_err;
  logic w_chk_end;

  ysyx_25040111_axi_rchk #(
    .ARID_VAL (ARID_VAL)
  ) u_rchk (
    .i_rid   (rid),
    .i_rlast (rlast),
    .i_cnt   (r_cnt),
    .i_arlen (r_arlen),
    .o_err   (w_chk_err),
    .o_end   (w_chk_end)
  );

  assign w_beat_err = rresp[1] | w_chk_err;
  assign w_beat_end = w_chk_end;
`else
  assign w_beat_err = rresp[1];
  assign w_beat_end = rlast;
`endif

  // Refill FSM: latch request, hold AR until accepted, forward R beats.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_err     <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_rok     <= 1'b0;
      r_rdone   <= 1'b0;
      r_rerr    <= 1'b0;
      r_busy    <= 1'b0;
      r_rdata   <= 32'd0;
      r_araddr  <= 32'd0;
      r_arlen   <= 8'd0;
    end else begin
      r_rok   <= 1'b0;
      r_rdone <= 1'b0;
      r_rerr  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (rstart) begin
            r_araddr  <= raddr & ~32'h3;
            r_arlen   <= (rlen > MAX_LEN) ? MAX_LEN : rlen;
            r_cnt     <= 8'd0;
            r_err     <= 1'b0;
            r_busy    <= 1'b1;
            r_arvalid <= 1'b1;
            r_state   <= ADDR;
          end
        end
        ADDR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= DATA;
          end
        end
        DATA: begin
          if (w_rhs) begin
            r_rok   <= 1'b1;
            r_rdata <= axi_rdata;
            r_cnt   <= r_cnt + 8'd1;
            r_err   <= r_err | w_beat_err;
            if (w_beat_end) begin
              r_rdone  <= 1'b1;
              r_rerr   <= r_err | w_beat_err;
              r_busy   <= 1'b0;
              r_rready <= 1'b0;
              r_state  <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rok     = r_rok;
  assign rdata   = r_rdata;
  assign rdone   = r_rdone;
  assign rerr    = r_rerr;
  assign busy    = r_busy;
  assign arvalid = r_arvalid;
  assign araddr  = r_araddr;
  assign arlen   = r_arlen;
  assign rready  = r_rready;
  assign arid    = ARID_VAL;
  assign arsize  = SIZE_4B;
  assign arburst = BURST_INCR;

endmodule

// File: tb/tb_ysyx_25040111_refill_axi_rd.sv
// Bench for the refill AXI read master: directed and random bursts.
// Expected beats, rdone position and rerr come from a burst-level model.
module tb_ysyx_25040111_refill_axi_rd;

  localparam logic [3:0] ARID = 4'd5;
  localparam logic [7:0] MAXL = 8'd15;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rstart = 1'b0;
  logic [31:0] raddr = 32'd0;
  logic [7:0]  rlen = 8'd0;
  logic        rok;
  logic [31:0] rdata;
  logic        rdone;
  logic        rerr;
  logic        busy;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] axi_rdata = 32'd0;
  logic [1:0]  rresp = 2'd0;
  logic        rlast = 1'b0;
  logic [3:0]  rid = 4'd0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  ysyx_25040111_refill_axi_rd #(
    .ARID_VAL (ARID),
    .MAX_LEN  (MAXL)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rstart    (rstart),
    .raddr     (raddr),
    .rlen      (rlen),
    .rok       (rok),
    .rdata     (rdata),
    .rdone     (rdone),
    .rerr      (rerr),
    .busy      (busy),
    .arvalid   (arvalid),
    .arready   (arready),
    .araddr    (araddr),
    .arid      (arid),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .rvalid    (rvalid),
    .rready    (rready),
    .axi_rdata (axi_rdata),
    .rresp     (rresp),
    .rlast     (rlast),
    .rid       (rid)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    int          nsend;
    int          ar_dly;
    int          gap;
    int          err_b;
    int          rid_b;
    int          rst_at;
    logic [31:0] d0;
    bit          poke;
    bit          chained;
    bit          chain_next;
    logic [31:0] n_addr;
    logic [7:0]  n_len;
  } stim_t;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] clamp(input logic [7:0] l);
    return (l > MAXL) ? MAXL : l;
  endfunction

  function automatic stim_t mk(input logic [31:0] a,
                               input logic [7:0] l);
    stim_t s;
    s.addr = a;
    s.len = l;
    s.nsend = int'(clamp(l)) + 1;
    s.ar_dly = 0;
    s.gap = 0;
    s.err_b = -1;
    s.rid_b = -1;
    s.rst_at = -1;
    s.d0 = 32'd0;
    s.poke = 1'b0;
    s.chained = 1'b0;
    s.chain_next = 1'b0;
    s.n_addr = 32'd0;
    s.n_len = 8'd0;
    return s;
  endfunction

  // Index of the beat that closes the burst.
  function automatic int end_idx(input int nsend, input int alen);
`ifdef YSYX_25040111_AXI_CHK_EN
    return (nsend - 1 < alen) ? nsend - 1 : alen;
`else
    return nsend - 1 + 0 * alen;
`endif
  endfunction

  task automatic burst(input stim_t s);
    logic [31:0] ea;
    logic [7:0]  el;
    logic [31:0] d;
    logic        eerr;
    int          e_end;
    int          g;
    ea = s.addr & ~32'h3;
    el = clamp(s.len);
    e_end = end_idx(s.nsend, int'(el));
    eerr = 1'b0;
    if (!s.chained) begin
      @(negedge clock);
      rstart = 1'b1;
      raddr = s.addr;
      rlen = s.len;
      arready = (s.ar_dly == 0);
    end
    @(negedge clock);
    rstart = 1'b0;
    raddr = $urandom;
    rlen = 8'($urandom);
    chk("arvalid", 32'(arvalid), 32'd1);
    chk("araddr", araddr, ea);
    chk("arlen", 32'(arlen), 32'(el));
    chk("busy", 32'(busy), 32'd1);
    chk("rready_addr", 32'(rready), 32'd0);
    chk("arid", 32'(arid), 32'(ARID));
    chk("arsize", 32'(arsize), 32'd2);
    chk("arburst", 32'(arburst), 32'd1);
    for (int i = 0; i < s.ar_dly; i++) begin
      arready = 1'b0;
      @(negedge clock);
      chk("ar_hold_v", 32'(arvalid), 32'd1);
      chk("ar_hold_a", araddr, ea);
      chk("ar_hold_l", 32'(arlen), 32'(el));
    end
    arready = 1'b1;
    @(negedge clock);
    arready = 1'b0;
    chk("ar_done", 32'(arvalid), 32'd0);
    chk("rready", 32'(rready), 32'd1);
    for (int b = 0; b < s.nsend; b++) begin
      if (b == s.rst_at) begin
        rvalid = 1'b1;
        axi_rdata = $urandom;
        rresp = 2'd0;
        rlast = 1'b0;
        rid = ARID;
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_rok", 32'(rok), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_arlen", 32'(arlen), 32'd0);
        @(negedge clock);
        chk("rst_hold_rok", 32'(rok), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        rvalid = 1'b0;
        chk("post_rst_rok", 32'(rok), 32'd0);
        chk("post_rst_rready", 32'(rready), 32'd0);
        chk("post_rst_arvalid", 32'(arvalid), 32'd0);
        return;
      end
      g = 0;
      while (g < 3 && $urandom_range(99) < s.gap) begin
        rvalid = 1'b0;
        @(negedge clock);
        chk("gap_rok", 32'(rok), 32'd0);
        g++;
      end
      d = (b == 0 && s.d0 != 0) ? s.d0 : $urandom;
      rvalid = 1'b1;
      axi_rdata = d;
      rresp = (b == s.err_b) ? 2'(2 + $urandom_range(1))
                             : 2'($urandom_range(1));
      rlast = (b == s.nsend - 1);
      rid = (b == s.rid_b) ? (ARID ^ 4'(1 + $urandom_range(14))) : ARID;
      eerr = eerr | rresp[1];
`ifdef YSYX_25040111_AXI_CHK_EN
      eerr = eerr | (rid != ARID) | (rlast != (b == int'(el)));
`endif
      if (s.poke && b == 0) begin
        rstart = 1'b1;
        raddr = ~s.addr;
        rlen = 8'd2;
      end
      @(negedge clock);
      rstart = 1'b0;
      chk("rok", 32'(rok), 32'd1);
      chk("rdata", rdata, d);
      chk("rdone", 32'(rdone), 32'(b == e_end));
      chk("busy_beat", 32'(busy), 32'(b != e_end));
      if (b == e_end) begin
        chk("rerr", 32'(rerr), 32'(eerr));
        break;
      end
      chk("rerr_mid", 32'(rerr), 32'd0);
    end
    rvalid = 1'b0;
    rlast = 1'b0;
    if (s.chain_next) begin
      rstart = 1'b1;
      raddr = s.n_addr;
      rlen = s.n_len;
      arready = 1'b0;
      return;
    end
    @(negedge clock);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_rok", 32'(rok), 32'd0);
    chk("idle_rdone", 32'(rdone), 32'd0);
    chk("idle_rready", 32'(rready), 32'd0);
    chk("idle_arvalid", 32'(arvalid), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    repeat (2) @(negedge clock);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_rok", 32'(rok), 32'd0);
    chk("rst_rdone", 32'(rdone), 32'd0);
    chk("rst_rerr", 32'(rerr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_arlen", 32'(arlen), 32'd0);
    chk("rst_arid", 32'(arid), 32'(ARID));
    chk("rst_arsize", 32'(arsize), 32'd2);
    chk("rst_arburst", 32'(arburst), 32'd1);
    reset = 1'b1;

    s = mk(32'h3000_0006, 8'd0);
    s.d0 = 32'hDEAD_BEEF;
    burst(s);

    s = mk(32'h8000_0100, 8'd3);
    s.ar_dly = 3;
    s.gap = 50;
    burst(s);

    s = mk(32'h8000_0203, 8'd3);
    s.err_b = 1;
    burst(s);

    s = mk(32'h8000_0300, 8'd3);
    s.poke = 1'b1;
    burst(s);

    s = mk(32'h8000_0400, 8'd1);
    s.chain_next = 1'b1;
    s.n_addr = 32'h8000_0501;
    s.n_len = 8'd2;
    burst(s);
    s = mk(32'h8000_0501, 8'd2);
    s.chained = 1'b1;
    s.ar_dly = 1;
    burst(s);

    s = mk(32'h8000_0600, 8'd3);
    s.rst_at = 2;
    burst(s);
    s = mk(32'h8000_0700, 8'd3);
    burst(s);

    s = mk(32'h8000_0800, 8'd3);
    s.nsend = 2;
    burst(s);

    s = mk(32'h8000_0900, 8'd3);
    s.nsend = 6;
    burst(s);

    s = mk(32'h8000_0A00, 8'd2);
    s.rid_b = 1;
    burst(s);

    s = mk(32'h8000_0B00, 8'd40);
    burst(s);

    for (int k = 0; k < 25; k++) begin
      s = mk($urandom, 8'($urandom_range(20)));
      s.ar_dly = int'($urandom_range(3));
      s.gap = int'($urandom_range(60));
      if ($urandom_range(2) == 0)
        s.err_b = int'($urandom_range(s.nsend - 1));
      if ($urandom_range(3) == 0)
        s.rid_b = int'($urandom_range(s.nsend - 1));
      burst(s);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
